rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//  Consumer end of the bench clock/reset generators. Takes clk/rst plus a soft
//  reset request, qualifies the request, and drives ordered per-stage reset
//  release to NUM_STAGES downstream blocks, then raises sys_ready. Sits in the
//  harness between the clock/reset generators and the DUT/TB components.
// PARAMETERS
//  NUM_STAGES   3   number of staged reset outputs (1..8)
//  HOLD_CYC     16  cycles all stages stay in reset before stage 0 releases (>=1)
//  GAP_CYC      4   cycles between release of stage k and stage k+1 (>=1)
//  MIN_REQ_CYC  3   consecutive high samples of sw_rst_req needed to qualify (>=1)
//  GLITCH_W     8   width of glitch counter
// PORTS
//  clk          in   1           single clock, all logic on posedge
//  rst          in   1           synchronous, active-high reset
//  sw_rst_req   in   1           soft reset request, level, sampled on clk
//  stage_rst    out  NUM_STAGES  per-stage reset, active-high
//  sys_ready    out  1           all stages released
//  glitch_cnt   out  GLITCH_W    rejected short requests (RST_SEQ_GLITCH_CNT_EN only)
// BEHAVIOUR
//  - Reset: one clock, clk; rst is synchronous, active-high. While rst is sampled
//    high: stage_rst='1, sys_ready=0, glitch_cnt=0, state=HOLD, counters=0.
//  - FSM: HOLD -> RELEASE -> RUN; qualified request from RELEASE/RUN -> WAIT_LOW.
//  - T0 = first edge with rst sampled low. HOLD counts edges. stage_rst[0] is low
//    after edge T0+HOLD_CYC-1, so it is low after HOLD_CYC edges.
//  - RELEASE: stage_rst[k] is low after HOLD_CYC+k*GAP_CYC edges. Release is
//    strictly ordered; a stage never releases before a lower-index stage.
//  - sys_ready rises one edge after the last stage releases. It stays high in RUN.
//  - Qualification: active in RELEASE and RUN. On the edge where sw_rst_req has
//    been sampled high MIN_REQ_CYC consecutive times: stage_rst='1, sys_ready=0,
//    and the FSM moves to WAIT_LOW.
//  - WAIT_LOW: all stages stay asserted until sw_rst_req is sampled low. That edge
//    enters HOLD with the counter cleared. The HOLD_CYC count starts there, not
//    at qualification.
//  - Short request: sampled high for 1..MIN_REQ_CYC-1 edges and then low. No
//    effect on outputs or the FSM. This is a glitch event.
//  - sw_rst_req is ignored in HOLD and does not extend HOLD.
//  - rst asserted mid-sequence: immediate return to reset values on that edge.
//    This overrides any pending qualification.
//  - Counters size via clog2(max(HOLD_CYC,GAP_CYC,MIN_REQ_CYC)+1). No wrap is
//    possible.
// CONFIGURATION
//  - RST_SEQ_GLITCH_CNT_EN defined:
//    - glitch_cnt increments by 1 on each glitch event, on the edge where the
//      low is sampled. It saturates at all-ones.
//    - It is cleared only by rst; a soft reset does not clear it.
//  - RST_SEQ_GLITCH_CNT_EN undefined: glitch_cnt is tied to 0. No counter logic.
// STRUCTURE
//  - Package rst_seq_pkg holds:
//    - typedef enum {HOLD,RELEASE,RUN,WAIT_LOW} rst_seq_state_e;
//    - function cnt_w(int a,b,c) for counter width.
//  - Sub-module rst_req_qualifier holds the consecutive-high counter and the
//    qualify/glitch pulse outputs. The FSM and stage shifter stay in top.
// TESTING (defaults)
//  1. rst high 5 edges, then low -> stage_rst[0] low after 16 edges, [1] after 20,
//     [2] after 24; sys_ready high after 25.
//  2. In RUN, sw_rst_req high 3 edges -> stage_rst=3'b111 and sys_ready=0 after
//     the 3rd edge. Hold req high 10 more edges -> still 3'b111. Drop req ->
//     stage0 low 16 edges later.
//  3. In RUN, sw_rst_req high 2 edges then low -> outputs unchanged;
//     glitch_cnt=1 (0 with macro off).
//  4. 300 glitch pulses -> glitch_cnt saturates at 255.
//  5. rst asserted at edge 18 of sequence (stage0 released) -> next edge:
//     stage_rst=3'b111, sys_ready=0, glitch_cnt=0. Sequence restarts from T0.
//  6. sw_rst_req held high through HOLD -> ignored. Release timing is identical
//     to scenario 1, and qualification starts in RELEASE.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and helpers for the staged reset sequencer.
//
// Contents
//   rst_seq_state_e : sequencer FSM state encoding
//                     (HOLD, RELEASE, RUN, WAIT_LOW)
//   cnt_w()         : width of a counter that must hold the largest of three
//                     cycle counts without wrapping
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RELEASE  = 2'd1,
        RUN      = 2'd2,
        WAIT_LOW = 2'd3
    } rst_seq_state_e;

    // Enough bits to represent max(a,b,c). The +1 keeps exact powers of two
    // representable; the result is never below 1.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl_if
// Bundle between the harness (driver of the soft reset request, consumer of
// the staged resets) and the rst_seq_ctrl sequencer.
//
// Signals
//   sw_rst_req  : soft reset request, level-sensitive, sampled on clk
//   stage_rst   : per-stage active-high resets, NUM_STAGES wide
//   sys_ready   : every stage has been released
//   glitch_cnt  : count of rejected short requests (zero when the counter
//                 is compiled out)
//   state       : current sequencer state, for observation only
//
// Modports
//   master : harness side, drives sw_rst_req and observes everything else
//   slave  : sequencer side
//
// Handshake semantics: there is no valid/ready pair on this bundle. The
// request is a plain level; the sequencer samples it every posedge and only
// acts on it once it has been seen high for a qualifying run of cycles. The
// outputs are registered levels that a consumer may sample at any edge.
// -----------------------------------------------------------------------------
interface rst_seq_ctrl_if
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int GLITCH_W   = 8
);

    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  sys_ready;
    logic [GLITCH_W-1:0]   glitch_cnt;
    rst_seq_state_e        state;

    modport master (
        output sw_rst_req,
        input  stage_rst,
        input  sys_ready,
        input  glitch_cnt,
        input  state
    );

    modport slave (
        input  sw_rst_req,
        output stage_rst,
        output sys_ready,
        output glitch_cnt,
        output state
    );

endinterface

// File: rtl/rst_req_qualifier.sv
// -----------------------------------------------------------------------------
// rst_req_qualifier
// Counts consecutive high samples of the soft reset request while enabled.
//
// Ports
//   clk         : clock, posedge
//   rst         : synchronous active-high reset
//   i_en        : qualification window open (sequencer in RELEASE or RUN)
//   i_req       : soft reset request level
//   o_qualify   : combinational pulse on the edge that takes the
//                 MIN_REQ_CYC-th consecutive high sample
//   o_glitch    : combinational pulse on the edge where a low is sampled
//                 after 1..MIN_REQ_CYC-1 high samples
//
// Parameters
//   MIN_REQ_CYC : consecutive high samples needed to qualify (>=1)
//   CW          : counter width, must hold MIN_REQ_CYC-1
// -----------------------------------------------------------------------------
module rst_req_qualifier
    import rst_seq_pkg::*;
#(
    parameter int MIN_REQ_CYC = 3,
    parameter int CW          = cnt_w(MIN_REQ_CYC, 1, 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req,
    output logic o_qualify,
    output logic o_glitch
);

    // r_cnt holds the number of high samples already seen in the current run.
    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last    = (r_cnt == CW'(MIN_REQ_CYC - 1));
    assign o_qualify = i_en & i_req & w_last;
    // A nonzero count followed by a low sample can only be a short run,
    // because a full run clears the count on the qualifying edge.
    assign o_glitch  = i_en & ~i_req & (r_cnt != '0);

    // Outside the window the count is held at zero so that nothing seen
    // during HOLD or WAIT_LOW carries into the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || !i_req || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
// Staged reset sequencer. Holds every downstream stage in reset for HOLD_CYC
// edges, releases the stages in index order GAP_CYC edges apart, then raises
// sys_ready. A soft reset request that stays high for MIN_REQ_CYC samples
// re-asserts every stage and restarts the sequence once the request drops.
//
// Ports
//   clk   : clock, posedge
//   rst   : synchronous active-high reset
//   bus   : rst_seq_ctrl_if.slave (sw_rst_req in; stage_rst, sys_ready,
//           glitch_cnt, state out)
//
// Parameters
//   NUM_STAGES  : staged reset outputs (1..8)
//   HOLD_CYC    : edges all stages stay asserted before stage 0 releases (>=1)
//   GAP_CYC     : edges between consecutive stage releases (>=1)
//   MIN_REQ_CYC : consecutive high samples that qualify a request (>=1)
//   GLITCH_W    : glitch counter width
//
// Build option
//   RST_SEQ_GLITCH_CNT_EN : when defined, glitch_cnt counts rejected short
//   requests, saturating at all-ones and cleared only by rst. When undefined
//   glitch_cnt is tied to zero.
//
// FSM: HOLD -> RELEASE -> RUN; a qualified request in RELEASE or RUN goes to
// WAIT_LOW, which returns to HOLD on the first low sample of the request.
// -----------------------------------------------------------------------------
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYC    = 16,
    parameter int GAP_CYC     = 4,
    parameter int MIN_REQ_CYC = 3,
    parameter int GLITCH_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    rst_seq_ctrl_if.slave  bus
);

    localparam int CW = cnt_w(HOLD_CYC, GAP_CYC, MIN_REQ_CYC);

    // State codes kept as plain constants; they match rst_seq_state_e.
    localparam logic [1:0] S_HOLD     = 2'd0;
    localparam logic [1:0] S_RELEASE  = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_WAIT_LOW = 2'd3;

    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [NUM_STAGES-1:0] r_stage_rst;
    logic                  r_sys_ready;

    logic                  w_qual_en;
    logic                  w_qualify;
    logic                  w_glitch;
    logic                  w_hold_done;
    logic                  w_gap_done;

    assign w_qual_en   = (r_state == S_RELEASE) || (r_state == S_RUN);
    assign w_hold_done = (r_cnt == CW'(HOLD_CYC - 1));
    assign w_gap_done  = (r_cnt == CW'(GAP_CYC - 1));

    rst_req_qualifier #(
        .MIN_REQ_CYC (MIN_REQ_CYC),
        .CW          (CW)
    ) u_qual (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_qual_en),
        .i_req     (bus.sw_rst_req),
        .o_qualify (w_qualify),
        .o_glitch  (w_glitch)
    );

    // Stage releases shift a zero in from the bottom, so a higher stage can
    // never drop before every lower stage has already dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            r_stage_rst <= '1;
            r_sys_ready <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (w_hold_done) begin
                        r_stage_rst <= r_stage_rst << 1;
                        r_cnt       <= '0;
                        r_state     <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (w_qualify) begin
                        r_stage_rst <= '1;
                        r_sys_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT_LOW;
                    end else if (r_stage_rst == '0) begin
                        // One edge after the last release.
                        r_sys_ready <= 1'b1;
                        r_state     <= S_RUN;
                    end else if (w_gap_done) begin
                        r_stage_rst <= r_stage_rst << 1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (w_qualify) begin
                        r_stage_rst <= '1;
                        r_sys_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    // The hold period is timed from the request dropping,
                    // not from the qualifying edge.
                    if (!bus.sw_rst_req) begin
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
                    end
                end
                default: begin
                    r_state     <= S_HOLD;
                    r_cnt       <= '0;
                    r_stage_rst <= '1;
                    r_sys_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stage_rst = r_stage_rst;
    assign bus.sys_ready = r_sys_ready;
    assign bus.state     = rst_seq_state_e'(r_state);

`ifdef RST_SEQ_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] r_glitch_cnt;

    // Survives soft resets; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign bus.glitch_cnt = r_glitch_cnt;
`else
    logic w_unused_glitch;

    assign w_unused_glitch = w_glitch;
    assign bus.glitch_cnt  = {GLITCH_W{1'b0}};
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  localparam int NS = 3;
  localparam int GW = 8;
`ifdef RST_SEQ_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.NUM_STAGES(NS), .GLITCH_W(GW)) bus ();

  rst_seq_ctrl #(
    .NUM_STAGES  (NS),
    .HOLD_CYC    (16),
    .GAP_CYC     (4),
    .MIN_REQ_CYC (3),
    .GLITCH_W    (GW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int glitches = 0;  // glitch events generated by the bench

  function automatic int exp_glitch();
    if (!GC_EN) return 0;
    return (glitches > 255) ? 255 : glitches;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [NS-1:0] stg, input logic rdy,
                         input rst_seq_state_e st);
    chk({name, ".stage_rst"}, int'(bus.stage_rst), int'(stg));
    chk({name, ".sys_ready"}, int'(bus.sys_ready), int'(rdy));
    chk({name, ".state"}, int'(bus.state), int'(st));
  endtask

  // ---------------- driver tasks ----------------
  // Advance n posedges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- release-timing vectors ----------------
  typedef struct {
    int             edge_n;   // edges since T0
    logic [NS-1:0]  stage;
    logic           ready;
    rst_seq_state_e st;
  } vec_t;

  vec_t vec [10];

  // hold_req: keep sw_rst_req high for every edge up to and including the
  // HOLD exit edge (16), low afterwards.
  task automatic run_table(input string tag, input bit hold_req);
    int e;
    e = 0;
    for (int i = 0; i < 10; i++) begin
      bus.sw_rst_req = hold_req && (vec[i].edge_n <= 16);
      step(vec[i].edge_n - e);
      e = vec[i].edge_n;
      chk_all($sformatf("%s.e%0d", tag, vec[i].edge_n), vec[i].stage, vec[i].ready, vec[i].st);
    end
    bus.sw_rst_req = 1'b0;
  endtask

  initial begin
    vec[0] = '{1,  3'b111, 1'b0, HOLD};
    vec[1] = '{15, 3'b111, 1'b0, HOLD};
    vec[2] = '{16, 3'b110, 1'b0, RELEASE};
    vec[3] = '{19, 3'b110, 1'b0, RELEASE};
    vec[4] = '{20, 3'b100, 1'b0, RELEASE};
    vec[5] = '{23, 3'b100, 1'b0, RELEASE};
    vec[6] = '{24, 3'b000, 1'b0, RELEASE};
    vec[7] = '{25, 3'b000, 1'b1, RUN};
    vec[8] = '{26, 3'b000, 1'b1, RUN};
    vec[9] = '{30, 3'b000, 1'b1, RUN};

    rst = 1'b1;
    bus.sw_rst_req = 1'b0;

    // Reset values
    step(5);
    chk_all("reset", 3'b111, 1'b0, HOLD);
    chk("reset.glitch_cnt", int'(bus.glitch_cnt), 0);
    rst = 1'b0;

    // Power-on release sequence
    run_table("seq1", 1'b0);

    // Qualified soft reset from RUN, held long, then dropped
    bus.sw_rst_req = 1'b1;
    step(2);
    chk_all("soft.2hi", 3'b000, 1'b1, RUN);
    step(1);
    chk_all("soft.3hi", 3'b111, 1'b0, WAIT_LOW);
    step(10);
    chk_all("soft.held", 3'b111, 1'b0, WAIT_LOW);
    bus.sw_rst_req = 1'b0;
    step(1);
    chk_all("soft.drop", 3'b111, 1'b0, HOLD);
    step(15);
    chk_all("soft.hold15", 3'b111, 1'b0, HOLD);
    step(1);
    chk_all("soft.hold16", 3'b110, 1'b0, RELEASE);
    chk("soft.glitch_cnt", int'(bus.glitch_cnt), exp_glitch());
    step(9);
    chk_all("soft.run", 3'b000, 1'b1, RUN);

    // Short requests in RUN: 2 highs, then 1 high
    bus.sw_rst_req = 1'b1;
    step(2);
    bus.sw_rst_req = 1'b0;
    step(1);
    glitches++;
    chk_all("glitch2", 3'b000, 1'b1, RUN);
    chk("glitch2.glitch_cnt", int'(bus.glitch_cnt), exp_glitch());
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    step(1);
    glitches++;
    chk("glitch1.glitch_cnt", int'(bus.glitch_cnt), exp_glitch());

    // Saturation
    for (int i = 0; i < 300; i++) begin
      bus.sw_rst_req = 1'b1;
      step(1);
      bus.sw_rst_req = 1'b0;
      step(1);
      glitches++;
    end
    chk("sat.glitch_cnt", int'(bus.glitch_cnt), exp_glitch());
    chk_all("sat", 3'b000, 1'b1, RUN);

    // Soft reset keeps the glitch count; then rst in mid-release with a
    // qualification pending on the same edge.
    bus.sw_rst_req = 1'b1;
    step(3);
    chk_all("soft2.qual", 3'b111, 1'b0, WAIT_LOW);
    bus.sw_rst_req = 1'b0;
    step(1);
    chk("soft2.glitch_kept", int'(bus.glitch_cnt), exp_glitch());
    step(16);
    chk_all("soft2.rel0", 3'b110, 1'b0, RELEASE);
    bus.sw_rst_req = 1'b1;
    step(2);
    chk_all("soft2.pend", 3'b110, 1'b0, RELEASE);
    rst = 1'b1;
    step(1);
    glitches = 0;
    chk_all("midrst", 3'b111, 1'b0, HOLD);
    chk("midrst.glitch_cnt", int'(bus.glitch_cnt), 0);
    bus.sw_rst_req = 1'b0;
    step(1);
    rst = 1'b0;
    run_table("seq2", 1'b0);

    // Request held through HOLD is ignored
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    run_table("seq3", 1'b1);
    chk("seq3.glitch_cnt", int'(bus.glitch_cnt), exp_glitch());

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
